// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with per-stage valid/stall/flush, bubble collapse
// and youngest-producer forwarding lookup. Optional bubble counter under PIPE_PERF_EN.
module pipe_stage_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32,
  parameter int RW     = 5,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [RW-1:0]             in_dst,
  input  logic                      in_wen,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [RW-1:0]             out_dst,
  output logic                      out_wen,
  input  logic                      out_ready,
  output logic [STAGES-1:0]         stage_valid,
  input  logic [RW-1:0]             src_addr,
  output logic                      fwd_hit,
  output logic [$clog2(STAGES)-1:0] fwd_stage,
  output logic [WIDTH-1:0]          fwd_data,
  output logic [CNT_W-1:0]          perf_bubble_cnt
);

  localparam int SW = $clog2(STAGES);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] wen;
  logic [WIDTH-1:0]  data [STAGES];
  logic [RW-1:0]     dst  [STAGES];

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] up_hold;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_wen;
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [RW-1:0]     src_dst  [STAGES];

  // Backpressure ripples from the oldest stage; an empty stage absorbs it.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1] | (valid[STAGES-1] & ~out_ready);
    for (int unsigned i = 1; i < STAGES; i++) begin
      hold[STAGES-1-i] = stall[STAGES-1-i] | (valid[STAGES-1-i] & hold[STAGES-i]);
    end
  end

  always_comb begin
    src_valid[0] = in_valid;
    src_wen[0]   = in_wen;
    src_data[0]  = in_data;
    src_dst[0]   = in_dst;
    up_hold[0]   = 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid[k-1];
      src_wen[k]   = wen[k-1];
      src_data[k]  = data[k-1];
      src_dst[k]   = dst[k-1];
      up_hold[k]   = hold[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      wen   <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data[k] <= '0;
        dst[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          valid[k] <= 1'b0;
        end else if (hold[k]) begin
          valid[k] <= valid[k];
        end else if (up_hold[k]) begin
          valid[k] <= 1'b0;
        end else begin
          valid[k] <= src_valid[k];
          if (src_valid[k]) begin
            data[k] <= src_data[k];
            dst[k]  <= src_dst[k];
            wen[k]  <= src_wen[k];
          end
        end
      end
    end
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = valid[STAGES-1];
  assign out_data    = data[STAGES-1];
  assign out_dst     = dst[STAGES-1];
  assign out_wen     = valid[STAGES-1] & wen[STAGES-1];
  assign stage_valid = valid;

  // Ascending scan with first-hit guard selects the youngest producer.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stage = '0;
    fwd_data  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!fwd_hit && valid[k] && wen[k] && (dst[k] == src_addr) && (src_addr != '0)) begin
        fwd_hit   = 1'b1;
        fwd_stage = SW'(k);
        fwd_data  = data[k];
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!valid[STAGES-1] && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios then random traffic against a slot-occupancy model.
module tb_pipe_stage_chain;
  localparam int S  = 4;
  localparam int W  = 32;
  localparam int R  = 5;
  localparam int CW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [R-1:0]  in_dst;
  logic          in_wen;
  logic          in_ready;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [R-1:0]  out_dst;
  logic          out_wen;
  logic          out_ready;
  logic [S-1:0]  stage_valid;
  logic [R-1:0]  src_addr;
  logic          fwd_hit;
  logic [SW-1:0] fwd_stage;
  logic [W-1:0]  fwd_data;
  logic [CW-1:0] perf_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_chain #(.STAGES(S), .WIDTH(W), .RW(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst), .in_wen(in_wen),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst), .out_wen(out_wen),
    .out_ready(out_ready), .stage_valid(stage_valid), .src_addr(src_addr),
    .fwd_hit(fwd_hit), .fwd_stage(fwd_stage), .fwd_data(fwd_data),
    .perf_bubble_cnt(perf_bubble_cnt)
  );

  typedef struct {
    bit         v;
    bit [W-1:0] d;
    bit [R-1:0] dst;
    bit         w;
  } item_t;

  item_t       slot [S];
  int unsigned m_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A slot can take a new item if it is not stalled and is empty or its item moves on.
  function automatic bit [S-1:0] open_slots();
    bit [S-1:0] o;
    o[S-1] = !stall[S-1] && (!slot[S-1].v || out_ready);
    for (int k = S - 2; k >= 0; k--)
      o[k] = !stall[k] && (!slot[k].v || o[k+1]);
    return o;
  endfunction

  task automatic compare();
    bit [S-1:0] o;
    bit [S-1:0] sv;
    bit         hit;
    int         hs;
    bit [W-1:0] hd;
    o   = open_slots();
    hit = 0; hs = 0; hd = '0;
    for (int k = 0; k < S; k++) begin
      sv[k] = slot[k].v;
      if (!hit && slot[k].v && slot[k].w && slot[k].dst == src_addr && src_addr != 0) begin
        hit = 1; hs = k; hd = slot[k].d;
      end
    end
    check("in_ready", in_ready, o[0]);
    check("out_valid", out_valid, slot[S-1].v);
    check("out_wen", out_wen, slot[S-1].v & slot[S-1].w);
    check("stage_valid", stage_valid, sv);
    if (slot[S-1].v) begin
      check("out_data", out_data, slot[S-1].d);
      check("out_dst", out_dst, slot[S-1].dst);
    end
    check("fwd_hit", fwd_hit, hit);
    check("fwd_stage", fwd_stage, hs);
    check("fwd_data", fwd_data, hd);
`ifdef PIPE_PERF_EN
    check("perf_cnt", perf_bubble_cnt, m_cnt);
`else
    check("perf_cnt", perf_bubble_cnt, 0);
`endif
  endtask

  task automatic model_edge();
    bit [S-1:0] o;
    bit [S-1:0] leave;
    item_t      nxt [S];
    item_t      src;
    if (rst) begin
      for (int k = 0; k < S; k++) slot[k] = '{0, '0, '0, 0};
      m_cnt = 0;
      return;
    end
    o = open_slots();
    leave[S-1] = slot[S-1].v && !stall[S-1] && out_ready;
    for (int k = 0; k < S - 1; k++) leave[k] = slot[k].v && !stall[k] && o[k+1];
    if (!slot[S-1].v && m_cnt < (1 << CW) - 1) m_cnt++;
    for (int k = 0; k < S; k++) begin
      nxt[k] = slot[k];
      if (k == 0) begin
        src = '{in_valid, in_data, in_dst, in_wen};
      end else begin
        src   = slot[k-1];
        src.v = leave[k-1];
      end
      if (flush[k]) nxt[k].v = 0;
      else if (o[k]) begin
        if (src.v) nxt[k] = src;
        else nxt[k].v = 0;
      end
    end
    for (int k = 0; k < S; k++) slot[k] = nxt[k];
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [R-1:0] r, input logic w);
    in_valid = 1; in_data = d; in_dst = r; in_wen = w;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; stall = '0; flush = '0; out_ready = 1; src_addr = '0;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_dst = '0; in_wen = 0;
    stall = '0; flush = '0; out_ready = 1; src_addr = '0;
    @(posedge clk);
    model_edge();
    #1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_stage_valid", stage_valid, 0);
    rst = 0;

    // In-order delivery and stage walk
    push(32'h11, 5'd1, 1); check("walk1", stage_valid, 4'b0001);
    push(32'h22, 5'd2, 1); check("walk2", stage_valid, 4'b0011);
    push(32'h33, 5'd3, 1); check("walk3", stage_valid, 4'b0111);
    idle(1); check("walk4", stage_valid, 4'b1110); check("lat_11", out_data, 32'h11);
    idle(1); check("walk5", stage_valid, 4'b1100); check("lat_22", out_data, 32'h22);
    idle(1); check("walk6", stage_valid, 4'b1000); check("lat_33", out_data, 32'h33);
    idle(1); check("walk7", stage_valid, 4'b0000);

    // Mid-pipe stall drains the tail only
    for (int i = 0; i < 4; i++) push(32'h40 + i, 5'd4, 1);
    check("full", stage_valid, 4'b1111);
    stall = 4'b0100;
    push(32'h50, 5'd4, 1);
    check("stall_sv", stage_valid, 4'b0111);
    check("stall_ready", in_ready, 0);
    push(32'h51, 5'd4, 1);
    check("stall_sv2", stage_valid, 4'b0111);
    stall = '0;
    idle(6);

    // Bubble collapse under output backpressure
    do_reset();
    push(32'hA0, 5'd1, 1); push(32'hC0, 5'd1, 1); idle(1); push(32'hB0, 5'd1, 1);
    check("gap_sv", stage_valid, 4'b1101);
    out_ready = 0;
    check("collapse_ready", in_ready, 1);
    idle(1);
    check("collapse_sv", stage_valid, 4'b1110);
    out_ready = 1;
    idle(5);

    // Flush beats stall
    push(32'hAA, 5'd2, 1); idle(1);
    check("aa_in_s1", stage_valid, 4'b0010);
    stall = 4'b0010; flush = 4'b0010;
    idle(1);
    stall = '0; flush = '0;
    check("flush_sv", stage_valid, 4'b0000);
    idle(4);

    // Youngest producer wins; register 0 never forwards
    push(32'h300, 5'd5, 1); push(32'h200, 5'd0, 1); push(32'h100, 5'd5, 1);
    in_valid = 0; out_ready = 0;
    step();
    src_addr = 5'd5;
    #1;
    check("fwd5_hit", fwd_hit, 1); check("fwd5_stage", fwd_stage, 1); check("fwd5_data", fwd_data, 32'h100);
    src_addr = 5'd0;
    #1;
    check("fwd0_hit", fwd_hit, 0); check("fwd0_data", fwd_data, 0);
    out_ready = 1;
    idle(5);

    // Bubble counter saturation and clear
    do_reset();
    idle(20);
`ifdef PIPE_PERF_EN
    check("perf_sat", perf_bubble_cnt, 15);
`else
    check("perf_off", perf_bubble_cnt, 0);
`endif
    do_reset();
    check("perf_clr", perf_bubble_cnt, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = $urandom;
      in_dst    = R'($urandom_range(0, 7));
      in_wen    = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      src_addr  = R'($urandom_range(0, 7));
      for (int k = 0; k < S; k++) begin
        stall[k] = $urandom_range(0, 7) == 0;
        flush[k] = $urandom_range(0, 15) == 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
